// File: rtl/link_slave_fifo.sv
// Receive side of a 4-phase req/ack link: captures one word per req pulse into a
// first-word-fall-through FIFO and withholds ack while the FIFO is full.
module link_slave_fifo #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ACK_HOLD = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req,
    input  logic [DATA_W-1:0]        data_in,
    output logic                     ack,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [DATA_W-1:0]        last_data,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     stall,
    output logic [CNT_W-1:0]         accept_cnt
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned FILL_W = PTR_W + 1;
    localparam int unsigned HOLD_W = (ACK_HOLD > 1) ? $clog2(ACK_HOLD) : 1;
    localparam logic [FILL_W-1:0] FULL      = FILL_W'(DEPTH);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(ACK_HOLD - 1);

    typedef enum logic [1:0] {RIdle, RAckHold, RWaitReq0} state_e;

    state_e              state_q, state_d;
    logic                ack_q, ack_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [FILL_W-1:0]   fill_q;
    logic [DATA_W-1:0]   last_data_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                push, pop;

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        hold_d  = hold_q;
        push    = 1'b0;
        stall   = 1'b0;
        unique case (state_q)
            RIdle: begin
                // Full test uses occupancy before any same-cycle pop.
                if (req) begin
                    if (fill_q != FULL) begin
                        push    = 1'b1;
                        ack_d   = 1'b1;
                        hold_d  = HOLD_INIT;
                        state_d = RAckHold;
                    end else begin
                        stall = 1'b1;
                    end
                end
            end
            RAckHold: begin
                if (hold_q == '0) begin
                    state_d = RWaitReq0;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            RWaitReq0: begin
                if (!req) begin
                    ack_d   = 1'b0;
                    state_d = RIdle;
                end
            end
            default: state_d = RIdle;
        endcase
    end

    assign out_valid = (fill_q != '0);
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RIdle;
            ack_q       <= 1'b0;
            hold_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            last_data_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            hold_q  <= hold_d;
            if (push) begin
                wr_ptr_q    <= wr_ptr_q + PTR_W'(1);
                last_data_q <= data_in;
                cnt_q       <= cnt_q + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fill_q <= fill_q + FILL_W'(1);
                2'b01:   fill_q <= fill_q - FILL_W'(1);
                default: fill_q <= fill_q;
            endcase
        end
    end

    // Storage is not reset; out_data is masked to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    assign out_data   = out_valid ? mem[rd_ptr_q] : '0;
    assign ack        = ack_q;
    assign fill       = fill_q;
    assign last_data  = last_data_q;
    assign accept_cnt = cnt_q;

endmodule

// File: tb/tb_link_slave_fifo.sv
// Randomised scoreboard bench for link_slave_fifo, plus a small-parameter
// instance exercising the short ack hold and the accept counter wrap.
module tb_link_slave_fifo;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned ACK_HOLD = 2;
    localparam int unsigned CNT_W    = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req = 1'b0;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              ack, out_valid, stall;
    logic [DATA_W-1:0] out_data, last_data;
    logic [2:0]        fill;
    logic [CNT_W-1:0]  accept_cnt;

    logic              req2 = 1'b0;
    logic              out_ready2 = 1'b1;
    logic [7:0]        data2 = '0;
    logic              ack2, out_valid2, stall2;
    logic [7:0]        out_data2, last_data2;
    logic [1:0]        fill2;
    logic [1:0]        accept_cnt2;

    link_slave_fifo #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ACK_HOLD(ACK_HOLD), .CNT_W(CNT_W)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in), .ack(ack),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .last_data(last_data), .fill(fill), .stall(stall), .accept_cnt(accept_cnt)
    );

    link_slave_fifo #(
        .DATA_W(8), .DEPTH(2), .ACK_HOLD(1), .CNT_W(2)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .req(req2), .data_in(data2), .ack(ack2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .last_data(last_data2), .fill(fill2), .stall(stall2), .accept_cnt(accept_cnt2)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] exp_q[$];
    logic [7:0] cur_word = '0;
    int         captured = 0;
    int         popped = 0;
    int         acc_model = 0;
    int         occ_m;
    logic       prev_ack = 1'b0;
    bit         rand_mode = 1'b0;
    logic [7:0] w_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp_v, $time);
    endtask

    task automatic chk_ok(input string name, input bit ok);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got false, expected true at %0t", name, $time);
    endtask

    // Monitor: occupancy model is captures minus pops; data order comes from exp_q.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ack = 1'b0;
        end else begin
            if (ack && !prev_ack) begin
                captured++;
                acc_model++;
                chk("accept_cnt", 32'(accept_cnt), 32'(acc_model % 65536));
                chk("last_data", 32'(last_data), 32'(cur_word));
            end
            prev_ack = ack;
            occ_m = captured - popped;
            chk("fill", 32'(fill), 32'(occ_m));
            chk("out_valid", 32'(out_valid), 32'(occ_m != 0));
            chk("stall", 32'(stall), 32'(req && !ack && occ_m == int'(DEPTH)));
            if (out_valid && out_ready) begin
                chk_ok("pop_with_model_empty", exp_q.size() != 0);
                if (exp_q.size() != 0) begin
                    w_m = exp_q.pop_front();
                    chk("out_data", 32'(out_data), 32'(w_m));
                    popped++;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_mode) begin
            #1 out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // Called at the first negedge where ack is seen high; holds req for d samples.
    task automatic complete_hs(input int d);
        int high = 1;
        int n = 0;
        int want;
        for (int i = 1; i < d; i++) begin
            @(negedge clk);
            if (ack) high++;
        end
        #1 req = 1'b0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (!ack) break;
            high++;
        end
        chk_ok("ack_release_timeout", !ack);
        want = (d > int'(ACK_HOLD) + 1) ? d : int'(ACK_HOLD) + 1;
        chk("ack_high_cycles", 32'(high), 32'(want));
    endtask

    task automatic wait_ack_high();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 200);
        chk_ok("ack_timeout", ack);
    endtask

    task automatic handshake(input logic [7:0] w, input int d);
        @(posedge clk);
        #1;
        req = 1'b1;
        data_in = w;
        cur_word = w;
        exp_q.push_back(w);
        wait_ack_high();
        if (ack) complete_hs(d);
        else req = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk_ok("drain_timeout", exp_q.size() == 0);
        @(negedge clk);
        chk("drained_fill", 32'(fill), 32'd0);
        chk("drained_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before 500000");
        $fatal(1);
    end

    initial begin
        logic [7:0] rw;
        int         n;
        int         high;

        // Reset with req held high and A5 on the bus.
        req = 1'b1;
        data_in = 8'hA5;
        cur_word = 8'hA5;
        exp_q.push_back(8'hA5);
        #1;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_fill", 32'(fill), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_last_data", 32'(last_data), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_accept_cnt", 32'(accept_cnt), 32'd0);
        #21 rst_n = 1'b1;
        @(negedge clk);
        chk("t1_ack", 32'(ack), 32'd1);
        chk("t1_out_data", 32'(out_data), 32'hA5);
        chk("t1_fill", 32'(fill), 32'd1);
        chk("t1_accept_cnt", 32'(accept_cnt), 32'd1);
        complete_hs(2);
        drain();

        // Fill to DEPTH, then a fifth request stalls until one pop frees a slot.
        handshake(8'h11, 1);
        handshake(8'h22, 1);
        handshake(8'h33, 2);
        handshake(8'h44, 1);
        chk("t2_full_fill", 32'(fill), 32'd4);
        fork
            handshake(8'h55, 1);
            begin
                repeat (2) @(negedge clk);
                chk("t2_stall", 32'(stall), 32'd1);
                chk("t2_stall_ack", 32'(ack), 32'd0);
                @(posedge clk);
                #1 out_ready = 1'b1;
                @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                chk("t2_no_push_on_pop", 32'(ack), 32'd0);
                chk("t2_fill_after_pop", 32'(fill), 32'd3);
                @(negedge clk);
                chk("t2_late_capture", 32'(ack), 32'd1);
                chk("t2_fill_refull", 32'(fill), 32'd4);
            end
        join
        drain();

        // Simultaneous push and pop at fill=2.
        handshake(8'h66, 1);
        handshake(8'h77, 1);
        chk("t4_fill2", 32'(fill), 32'd2);
        @(posedge clk);
        #1;
        req = 1'b1;
        data_in = 8'h88;
        cur_word = 8'h88;
        exp_q.push_back(8'h88);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("t4_fill_same", 32'(fill), 32'd2);
        chk("t4_ack", 32'(ack), 32'd1);
        complete_hs(1);
        drain();

        // Async reset in the middle of the ack hold.
        @(posedge clk);
        #1;
        req = 1'b1;
        data_in = 8'h5A;
        cur_word = 8'h5A;
        exp_q.push_back(8'h5A);
        wait_ack_high();
        #2 rst_n = 1'b0;
        #1;
        chk("t5_ack", 32'(ack), 32'd0);
        chk("t5_fill", 32'(fill), 32'd0);
        chk("t5_out_valid", 32'(out_valid), 32'd0);
        chk("t5_accept_cnt", 32'(accept_cnt), 32'd0);
        exp_q.delete();
        captured = 0;
        popped = 0;
        acc_model = 0;
        data_in = 8'h6C;
        cur_word = 8'h6C;
        exp_q.push_back(8'h6C);
        @(negedge clk);
        #2 rst_n = 1'b1;
        wait_ack_high();
        chk("t5_recapture_data", 32'(out_data), 32'h6C);
        if (ack) complete_hs(1);
        else req = 1'b0;
        drain();

        // Randomised traffic against the scoreboard.
        @(negedge clk);
        rand_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            rw = 8'($urandom_range(0, 255));
            handshake(rw, int'($urandom_range(1, 4)));
        end
        @(negedge clk);
        rand_mode = 1'b0;
        drain();

        // Small instance: ACK_HOLD=1, DEPTH=2, CNT_W=2, consumer always ready.
        for (int i = 0; i < 5; i++) begin
            rw = 8'(8'h90 + i);
            @(posedge clk);
            #1;
            req2 = 1'b1;
            data2 = rw;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!ack2 && n < 200);
            chk_ok("small_ack_timeout", ack2);
            chk("small_out_data", 32'(out_data2), 32'(rw));
            chk("small_accept_cnt", 32'(accept_cnt2), 32'((i + 1) % 4));
            high = 1;
            #1 req2 = 1'b0;
            n = 0;
            while (n < 200) begin
                @(negedge clk);
                n++;
                if (!ack2) break;
                high++;
            end
            chk_ok("small_release_timeout", !ack2);
            chk("small_ack_high_cycles", 32'(high), 32'd2);
        end
        chk("small_cnt_wrap", 32'(accept_cnt2), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
